// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter.
//
// Stores to the 16-byte window at BASE_ADDR push bytes into a TX FIFO. A frame
// FSM serialises them on tx_o as start bit, 8 data bits LSB first, optional even
// parity bit, and stop bit. Each bit lasts CLK_DIV clocks. Loads return status
// combinationally.
//
// Register map (offset = Address_i[3:2]):
//   0 TXDATA  W: push WriteData_i[7:0]     R: 0
//   1 STATUS  R: {ovf, busy, empty, full}  W: bit3=1 clears ovf
//   2 CTRL    R/W: bit0 en (reset 1)
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   Address_i    byte address from the core
//   WriteData_i  store data from the core
//   MemWrite_i   store strobe
//   ReadData_o   combinational read data, 0 when Sel_o=0
//   Sel_o        address falls inside this window
//   tx_o         serial line, registered, idle high
//   Busy_o       frame FSM not idle
//
// Configuration: define UART_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit (11-bit frame). Undefined gives a 10-bit frame.

`timescale 1ns/1ps

module uart_tx_mmio #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    input  logic                  MemWrite_i,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Sel_o,
    output logic                  tx_o,
    output logic                  Busy_o
);

    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BaudW = $clog2(CLK_DIV);

    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  CntFull    = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt_q;
    logic [BaudW-1:0]  baud_q;
    logic              tx_q;
    logic              en_q;
    logic              ovf_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
`ifdef UART_PARITY_EN
    logic              par_q;
`endif

    logic [1:0] offset;
    logic       wr_en;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       ovf_set;
    logic       ovf_clr;
    logic [7:0] head;
    logic       unused_bits;

    assign offset     = Address_i[3:2];
    assign Sel_o      = (Address_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en      = Sel_o & MemWrite_i;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntFull);
    assign pop        = (state_q == StIdle) & en_q & ~fifo_empty;
    assign push_req   = wr_en & (offset == 2'd0);
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign push       = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & ~pop;
    assign ovf_clr    = wr_en & (offset == 2'd1) & WriteData_i[3];
    assign head       = mem_q[rd_ptr_q];
    assign Busy_o     = (state_q != StIdle);
    assign tx_o       = tx_q;
    assign unused_bits = ^{Address_i[1:0], WriteData_i[DATA_WIDTH-1:8]};

    always_comb begin
        ReadData_o = '0;
        if (Sel_o) begin
            case (offset)
                2'd1:    ReadData_o[3:0] = {ovf_q, Busy_o, fifo_empty, fifo_full};
                2'd2:    ReadData_o[0]   = en_q;
                default: ReadData_o      = '0;
            endcase
        end
    end

    // FIFO storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= WriteData_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (wr_en && offset == 2'd2) begin
                en_q <= WriteData_i[0];
            end
            // Set has priority over a simultaneous clear.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Frame FSM. tx_q is registered from the current state, so the line trails
    // the state by one clock; this yields the two-edge write-to-start latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= head;
`ifdef UART_PARITY_EN
                        par_q     <= ^head;
`endif
                        bit_cnt_q <= '0;
                        baud_q    <= BaudReload;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    tx_q <= 1'b0;
                    if (baud_q == '0) begin
                        baud_q  <= BaudReload;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
                StData: begin
                    tx_q <= shift_q[0];
                    if (baud_q == '0) begin
                        baud_q    <= BaudReload;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    tx_q <= par_q;
                    if (baud_q == '0) begin
                        baud_q  <= BaudReload;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
`endif
                StStop: begin
                    tx_q <= 1'b1;
                    if (baud_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q - BaudW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps

module tb_uart_tx_mmio;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [31:0] BASE    = 32'h1001_0000;
`ifdef UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address_i = 32'h0;
    logic [31:0] WriteData_i = 32'h0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] ReadData_o;
    logic        Sel_o;
    logic        tx_o;
    logic        Busy_o;

    uart_tx_mmio #(
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Address_i   (Address_i),
        .WriteData_i (WriteData_i),
        .MemWrite_i  (MemWrite_i),
        .ReadData_o  (ReadData_o),
        .Sel_o       (Sel_o),
        .tx_o        (tx_o),
        .Busy_o      (Busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];
    int         frames_done = 0;
    int         wr_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line levels, index 0 = start bit, one entry per bit period.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f      = '0;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = ^d;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address_i   = a;
        WriteData_i = d;
        MemWrite_i  = 1'b1;
        wr_cyc      = cyc + 1;
        @(posedge clk);
        #1;
        MemWrite_i = 1'b0;
        Address_i  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Address_i  = a;
        MemWrite_i = 1'b0;
        #1;
        d = ReadData_o;
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        bus_write(BASE, {24'h0, b});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || Busy_o) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || Busy_o) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    // Monitor: decodes frames off the line and scores them against exp_q.
    logic [10:0] mon_got;
    int          mon_glitch;
    int          mon_start;
    bit          mon_abort;
    logic [7:0]  mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && tx_o === 1'b0) begin
                mon_start  = cyc;
                mon_got    = '0;
                mon_glitch = 0;
                mon_abort  = 1'b0;
                for (int k = 0; k < int'(FRAME) && !mon_abort; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        if (reset === 1'b1) mon_abort = 1'b1;
                    end
                    if (!mon_abort) begin
                        if (k % CLK_DIV == 0) mon_got[k / CLK_DIV] = tx_o;
                        else if (tx_o !== mon_got[k / CLK_DIV]) mon_glitch++;
                    end
                end
                if (!mon_abort) begin
                    frames_done++;
                    start_cyc_q.push_back(mon_start);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_got);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("frame_bits", 32'(mon_got), 32'(frame_bits(mon_exp)));
                        check("bit_glitches", mon_glitch, 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 50000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          busy_cnt;
        int          first_low;
        int          n0;
        int          tries;
        int          gap;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_tx", tx_o, 1);
        check("reset_busy", Busy_o, 0);
        check_read("reset_status", BASE + 4, 32'h2);
        check_read("reset_ctrl", BASE + 8, 32'h1);
        check_read("reserved_read", BASE + 12, 32'h0);
        check_read("txdata_read", BASE, 32'h0);

        // Single frame: latency and busy duration
        push_byte(8'hA5, 1'b1);
        busy_cnt  = 0;
        first_low = -1;
        for (int i = 0; i < int'(FRAME) + 20; i++) begin
            @(negedge clk);
            if (Busy_o === 1'b1) busy_cnt++;
            if (first_low < 0 && tx_o === 1'b0) first_low = cyc;
        end
        check("start_latency", first_low - wr_cyc, 2);
        check("busy_cycles", busy_cnt, FRAME);
        wait_idle(200);
        push_byte(8'h07, 1'b1);
        wait_idle(200);

        // Fill with en=0, overflow, clear, then push onto a full FIFO as it pops
        bus_write(BASE + 8, 32'h0);
        check_read("ctrl_off", BASE + 8, 32'h0);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b1);
        check_read("status_full", BASE + 4, 32'h1);
        push_byte(8'($urandom), 1'b0);
        check_read("status_ovf", BASE + 4, 32'h9);
        bus_write(BASE + 4, 32'h8);
        check_read("status_ovf_clr", BASE + 4, 32'h1);
        n0 = start_cyc_q.size();
        bus_write(BASE + 8, 32'h1);
        push_byte(8'($urandom), 1'b1);
        check_read("status_push_pop_full", BASE + 4, 32'h5);
        wait_idle(6 * FRAME + 100);
        check("burst_frames", start_cyc_q.size() - n0, 5);
        for (int i = 1; i < 5 && n0 + i < start_cyc_q.size(); i++) begin
            check("frame_gap", start_cyc_q[n0 + i] - start_cyc_q[n0 + i - 1], FRAME + 1);
        end
        check_read("status_drained", BASE + 4, 32'h2);

        // Clearing en mid-frame finishes the frame and stops further pops
        n0 = frames_done;
        push_byte(8'h3C, 1'b1);
        push_byte(8'hC3, 1'b1);
        repeat (3 * CLK_DIV) @(negedge clk);
        bus_write(BASE + 8, 32'h0);
        repeat (FRAME + 50) @(negedge clk);
        check("en_off_frames", frames_done - n0, 1);
        check_read("en_off_status", BASE + 4, 32'h0);
        bus_write(BASE + 8, 32'h1);
        wait_idle(3 * FRAME);
        check("en_on_frames", frames_done - n0, 2);

        // Store outside the window
        n0 = frames_done;
        @(negedge clk);
        Address_i   = BASE + 32'h10;
        WriteData_i = 32'h55;
        MemWrite_i  = 1'b1;
        #1;
        check("outside_sel", Sel_o, 0);
        check("outside_rdata", ReadData_o, 0);
        @(posedge clk);
        #1;
        MemWrite_i = 1'b0;
        @(negedge clk);
        Address_i = BASE + 4;
        #1;
        check("inside_sel", Sel_o, 1);
        check_read("outside_status", BASE + 4, 32'h2);
        repeat (2 * FRAME) @(negedge clk);
        check("outside_frames", frames_done - n0, 0);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            tries = 0;
            bus_read(BASE + 4, d);
            while (d[0] && tries < 500) begin
                bus_read(BASE + 4, d);
                tries++;
            end
            if (d[0]) begin
                vectors++;
                miscompares++;
                $display("FAIL fifo_stuck_full: got status 0x%0h, expected not full", d);
            end else begin
                push_byte(8'($urandom), 1'b1);
            end
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * FRAME))
                                              : int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end
        wait_idle(30 * FRAME);

        // Reset mid-DATA of the first frame with two bytes queued
        push_byte(8'h96, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        repeat (3 * CLK_DIV) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midreset_tx", tx_o, 1);
        check("midreset_busy", Busy_o, 0);
        reset = 1'b0;
        exp_q.delete();
        check_read("midreset_status", BASE + 4, 32'h2);
        check_read("midreset_ctrl", BASE + 8, 32'h1);
        n0 = frames_done;
        repeat (3 * FRAME) @(negedge clk);
        check("midreset_frames", frames_done - n0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
